counter_driver: RTL and testbench

- Stimulus/initiator side of the counter enable/clear/count interface.
- On a start request it:
  - issues one clear pulse,
  - issues a programmed number of enable pulses, optionally spaced by idle gap cycles,
  - reads back the counter's count and reports pass/fail.
- Sits beside a counter instance in sandbox and self-test wrappers and drives its i_en/i_clear inputs.

---
 rtl/counter_driver_pkg.sv | 21 ++
 rtl/counter_driver_expect.sv | 74 +++++++
 rtl/counter_driver.sv | 157 +++++++++++++++
 tb/tb_counter_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_driver_pkg.sv
// Shared types for the counter stimulus driver: FSM state encoding and latency bounds.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro COUNTER_DRIVER_TRACK_EN is consumed by counter_driver.sv.
package counter_driver_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        GAP   = 3'd3,
        WAIT  = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int CNT_LAT_MAX = 4;
    // Settle counter only has to count 0..CNT_LAT-1; the tracker must reach CNT_LAT itself.
    localparam int WAIT_W      = $clog2(CNT_LAT_MAX);
    localparam int LAT_W       = $clog2(CNT_LAT_MAX + 1);

endpackage

// File: rtl/counter_driver_expect.sv
// Expected-count tracker: models an ideal counter and delays its value by CNT_LAT to compare every cycle.
// Latency: mismatch flag is combinational on i_count; first-failure index is held in a register.
// Backpressure: none; follows the driver's o_en/o_clear pulses cycle by cycle.
module counter_driver_expect
    import counter_driver_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int CNT_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_window,
    input  logic [WIDTH-1:0] i_issued,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_fail,
    output logic [WIDTH-1:0] o_fail_idx
);

    logic [WIDTH-1:0] dly [CNT_LAT];
    logic [WIDTH-1:0] ideal_next;
    logic [LAT_W-1:0] since_clear;
    logic             fail_q;
    logic [WIDTH-1:0] idx_q;
    logic             cmp_en;
    logic             mismatch;

    // dly[0] is the ideal counter itself; later taps age it to match the real counter's latency.
    always_comb begin
        ideal_next = dly[0];
        if (i_clear) begin
            ideal_next = '0;
        end else if (i_en) begin
            ideal_next = dly[0] + WIDTH'(1);
        end
    end

    assign cmp_en   = i_window && (since_clear >= LAT_W'(CNT_LAT));
    assign mismatch = cmp_en && (i_count != dly[CNT_LAT-1]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < CNT_LAT; i++) begin
                dly[i] <= '0;
            end
            since_clear <= '0;
            fail_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            dly[0] <= ideal_next;
            for (int i = 1; i < CNT_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
            if (i_clear) begin
                since_clear <= LAT_W'(1);
            end else if (since_clear < LAT_W'(CNT_LAT)) begin
                since_clear <= since_clear + LAT_W'(1);
            end
            if (i_clear) begin
                fail_q <= 1'b0;
                idx_q  <= '0;
            end else if (mismatch && !fail_q) begin
                fail_q <= 1'b1;
                idx_q  <= i_issued;
            end
        end
    end

    // A mismatch landing in the CHECK cycle itself must still be reported that cycle.
    assign o_fail     = fail_q | mismatch;
    assign o_fail_idx = fail_q ? idx_q : i_issued;

endmodule

// File: rtl/counter_driver.sv
// Counter stimulus driver: clear, burst of (optionally gapped) enables, then count readback and pass/fail.
// Latency: run takes 1 + len + (len-1)*gap + CNT_LAT + 2 cycles; o_done pulses in the last one.
// Backpressure: i_start is honoured only in IDLE, never queued. Macro COUNTER_DRIVER_TRACK_EN adds per-cycle tracking.
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int GAP_WIDTH = 4,
    parameter int CNT_LAT   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_burst_len,
    input  logic [GAP_WIDTH-1:0] i_gap,
    output logic                 o_en,
    output logic                 o_clear,
    input  logic [WIDTH-1:0]     i_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_err_sticky,
    output logic [WIDTH-1:0]     o_fail_idx
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CNT_LAT - 1);

    state_t               state;
    logic [WIDTH-1:0]     len;
    logic [GAP_WIDTH-1:0] gap;
    logic [WIDTH-1:0]     issued;
    logic [WIDTH-1:0]     issued_inc;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 trk_fail;
    logic [WIDTH-1:0]     trk_idx;
    logic                 pass_now;

    assign issued_inc = issued + WIDTH'(1);

`ifdef COUNTER_DRIVER_TRACK_EN
    logic trk_window;

    assign trk_window = (state == RUN) || (state == GAP) || (state == WAIT) || (state == CHECK);

    counter_driver_expect #(
        .WIDTH   (WIDTH),
        .CNT_LAT (CNT_LAT)
    ) u_expect (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (o_en),
        .i_clear    (o_clear),
        .i_window   (trk_window),
        .i_issued   (issued),
        .i_count    (i_count),
        .o_fail     (trk_fail),
        .o_fail_idx (trk_idx)
    );
`else
    assign trk_fail = 1'b0;
    assign trk_idx  = '0;
`endif

    assign pass_now = (i_count == len) && !trk_fail;

    // Outputs are registered against the state being entered, so o_clear/o_en/o_done
    // are high exactly during the CLEAR/RUN/DONE cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            len          <= '0;
            gap          <= '0;
            issued       <= '0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            o_en         <= 1'b0;
            o_clear      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_err_sticky <= 1'b0;
            o_fail_idx   <= '0;
        end else begin
            o_en    <= 1'b0;
            o_clear <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        len     <= i_burst_len;
                        gap     <= i_gap;
                        o_clear <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    issued   <= '0;
                    wait_cnt <= WAIT_INIT;
                    if (len != '0) begin
                        o_en  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= WAIT;
                    end
                end
                RUN: begin
                    issued <= issued_inc;
                    if (issued_inc == len) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end else if (gap != '0) begin
                        gap_cnt <= gap;
                        state   <= GAP;
                    end else begin
                        o_en <= 1'b1;
                    end
                end
                GAP: begin
                    // gap_cnt counts down from gap to 1, so the all-ones gap is never truncated.
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        o_en  <= 1'b1;
                        state <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                CHECK: begin
                    o_done     <= 1'b1;
                    o_pass     <= pass_now;
                    o_fail_idx <= trk_fail ? trk_idx : '0;
                    if (!pass_now) begin
                        o_err_sticky <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_driver.sv
// Scoreboard bench for counter_driver driving a behavioural counter with optional skipped increment.
// Stimulus pushes hand-computed expectations; a negedge monitor pops them on every o_done.
module tb_counter_driver;

    localparam int WIDTH     = 12;
    localparam int GAP_WIDTH = 4;

`ifdef COUNTER_DRIVER_TRACK_EN
    localparam int IDX_FAULT4 = 3;
    localparam int IDX_FAULT6 = 2;
`else
    localparam int IDX_FAULT4 = 0;
    localparam int IDX_FAULT6 = 0;
`endif

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic [WIDTH-1:0]     i_burst_len = '0;
    logic [GAP_WIDTH-1:0] i_gap = '0;
    logic                 o_en;
    logic                 o_clear;
    logic [WIDTH-1:0]     i_count;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_pass;
    logic                 o_err_sticky;
    logic [WIDTH-1:0]     o_fail_idx;

    counter_driver #(
        .WIDTH     (WIDTH),
        .GAP_WIDTH (GAP_WIDTH),
        .CNT_LAT   (1)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_burst_len  (i_burst_len),
        .i_gap        (i_gap),
        .o_en         (o_en),
        .o_clear      (o_clear),
        .i_count      (i_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_err_sticky (o_err_sticky),
        .o_fail_idx   (o_fail_idx)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural counter, latency 1; the skip_idx-th enable (1-based) is dropped.
    logic [WIDTH-1:0] model_cnt = '0;
    int               model_en_seen = 0;
    int               skip_idx = 0;

    always @(posedge i_clk) begin
        if (o_clear) begin
            model_cnt     <= '0;
            model_en_seen <= 0;
        end else if (o_en) begin
            model_en_seen <= model_en_seen + 1;
            if (model_en_seen + 1 != skip_idx) begin
                model_cnt <= model_cnt + WIDTH'(1);
            end
        end
    end

    assign i_count = model_cnt;

    typedef struct {
        int len;
        int gap;
        int cycles;
        int pass;
        int err;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   exp_done = 0;
    int   busy_cnt = 0;
    int   off = 0;
    int   n_en = 0;
    int   n_clr = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pulse legality, enable spacing, and per-run scoreboard compare on o_done.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_en || o_clear) begin
            chk("en_clear_overlap", int'(o_en && o_clear), 0);
        end
        if (!o_busy) begin
            busy_cnt = 0;
            n_en     = 0;
            n_clr    = 0;
        end else begin
            busy_cnt++;
        end
        if (o_clear) begin
            off = 0;
            n_en = 0;
            n_clr++;
        end else begin
            off++;
        end
        if (o_en) begin
            if (sb.size() > 0) begin
                chk("en_spacing", off, 1 + n_en * (sb[0].gap + 1));
            end
            n_en++;
        end
        if (o_done) begin
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pass", int'(o_pass), e.pass);
                chk("err_sticky", int'(o_err_sticky), e.err);
                chk("fail_idx", int'(o_fail_idx), e.idx);
                chk("run_cycles", busy_cnt, e.cycles);
                chk("en_count", n_en, e.len);
                chk("clear_count", n_clr, 1);
            end
        end
    end

    task automatic push(input int len, input int gap, input int cycles,
                        input int pass, input int err, input int idx);
        exp_t e;
        e.len = len; e.gap = gap; e.cycles = cycles;
        e.pass = pass; e.err = err; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic start_run(input int len, input int gap, input int skip);
        @(negedge i_clk);
        skip_idx    = skip;
        i_burst_len = WIDTH'(len);
        i_gap       = GAP_WIDTH'(gap);
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        chk("done_timeout", int'(done_count >= target), 1);
    endtask

    task automatic run(input int len, input int gap, input int skip, input int cycles,
                       input int pass, input int err, input int idx);
        push(len, gap, cycles, pass, err, idx);
        start_run(len, gap, skip);
        exp_done++;
        wait_done(exp_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_en", int'(o_en), 0);
        chk("rst_clear", int'(o_clear), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_pass", int'(o_pass), 0);
        chk("rst_err", int'(o_err_sticky), 0);
        chk("rst_fail_idx", int'(o_fail_idx), 0);

        //  len gap skip cycles pass err idx
        run(5, 0,  0, 9,  1, 0, 0);
        run(3, 2,  0, 11, 1, 0, 0);
        run(0, 0,  0, 4,  1, 0, 0);
        run(2, 15, 0, 21, 1, 0, 0);
        run(4, 0,  3, 8,  0, 1, IDX_FAULT4);
        run(2, 1,  0, 7,  1, 1, 0);

        // Start while busy must be ignored.
        push(3, 1, 9, 1, 1, 0);
        start_run(3, 1, 0);
        exp_done++;
        repeat (2) @(negedge i_clk);
        i_burst_len = WIDTH'(7);
        i_gap       = '0;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(exp_done);
        repeat (3) @(negedge i_clk);
        chk("busy_after_ignored_start", int'(o_busy), 0);
        chk("sb_empty_after_ignored", sb.size(), 0);

        // Start held across DONE: ignored in DONE, accepted in the following IDLE cycle.
        push(1, 0, 5, 1, 1, 0);
        push(2, 0, 6, 1, 1, 0);
        start_run(1, 0, 0);
        exp_done++;
        n = 0;
        while (!o_done && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("done_seen", int'(o_done), 1);
        i_burst_len = WIDTH'(2);
        i_gap       = '0;
        i_start     = 1'b1;
        @(negedge i_clk);
        chk("idle_after_done_busy", int'(o_busy), 0);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("clear_after_idle_start", int'(o_clear), 1);
        exp_done++;
        wait_done(exp_done);

        run(6, 0, 2, 10, 0, 1, IDX_FAULT6);

        // Reset in the middle of RUN abandons the run.
        start_run(10, 0, 0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("midrst_en", int'(o_en), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_done", int'(o_done), 0);
        chk("midrst_err", int'(o_err_sticky), 0);
        chk("midrst_pass", int'(o_pass), 0);
        chk("midrst_fail_idx", int'(o_fail_idx), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (30) @(negedge i_clk);
        chk("no_done_after_rst", done_count, exp_done);

        run(1, 0, 0, 5, 1, 0, 0);

        repeat (3) @(negedge i_clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
